// File: rtl/jtcps1_pkg.sv
// Shared CPS1 GFX ROM arbitration constants: layer codes, bank offsets, FSM states.
package jtcps1_pkg;

  localparam int unsigned NumReq = 5;

  // Layer code doubles as the requester index
  typedef enum logic [2:0] {
    LayerObj  = 3'b000,
    LayerScr1 = 3'b001,
    LayerScr2 = 3'b010,
    LayerScr3 = 3'b011,
    LayerStar = 3'b100
  } layer_e;

  localparam logic [9:0]  BankAOffset = 10'd40;
  localparam logic [9:0]  BankBOffset = 10'd32;
  localparam logic [31:0] BlankWord   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBlank
  } arb_state_e;

endpackage

// File: rtl/jtcps1_gfx_mappers.sv
// Combinational layer-to-ROM-bank mapping of the upper address bits.
module jtcps1_gfx_mappers
  import jtcps1_pkg::*;
(
  input  logic [2:0] layer_i,
  input  logic [9:0] cin_i,
  output logic [9:0] cout_o
);

  // cin_i[6] is addr[16]; offset adds are 10-bit and never touch addr[9:0]
  always_comb begin
    cout_o = {1'b0, cin_i[8:0]};
    if (layer_i == LayerObj && cin_i[6]) begin
      cout_o = {7'd0, cin_i[2:0]} + BankAOffset;
    end else if (layer_i == LayerScr3) begin
      cout_o = {7'd0, cin_i[2:0]} + BankBOffset;
    end
  end

endmodule

// File: rtl/jtcps1_gfx_rom_arb.sv
// Round-robin arbiter sharing the GFX ROM between OBJ, SCR1-3 and STAR readers.
module jtcps1_gfx_rom_arb
  import jtcps1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        obj_cs_i,
  input  logic [19:0] obj_addr_i,
  output logic        obj_ok_o,
  output logic [31:0] obj_data_o,
  input  logic        scr1_cs_i,
  input  logic [19:0] scr1_addr_i,
  output logic        scr1_ok_o,
  output logic [31:0] scr1_data_o,
  input  logic        scr2_cs_i,
  input  logic [19:0] scr2_addr_i,
  output logic        scr2_ok_o,
  output logic [31:0] scr2_data_o,
  input  logic        scr3_cs_i,
  input  logic [19:0] scr3_addr_i,
  output logic        scr3_ok_o,
  output logic [31:0] scr3_data_o,
  input  logic        star_cs_i,
  input  logic [19:0] star_addr_i,
  output logic        star_ok_o,
  output logic [31:0] star_data_o,
  output logic        rom_cs_o,
  output logic [19:0] rom_addr_o,
  input  logic        rom_ok_i,
  input  logic [31:0] rom_data_i
);

  logic [NumReq-1:0] cs;
  logic [19:0]       addr [NumReq];

  arb_state_e        state_q;
  logic [2:0]        last_q;
  logic [2:0]        sel_q;
  logic              rom_cs_q;
  logic [19:0]       rom_addr_q;
  logic [NumReq-1:0] ok_q;
  logic [31:0]       data_q [NumReq];

  logic              gnt_vld;
  logic [2:0]        gnt_idx;
  logic [19:0]       gnt_raw;
  logic [19:0]       gnt_addr;
  logic              gnt_unmapped;
  logic [9:0]        gnt_cout;

  assign cs      = {star_cs_i, scr3_cs_i, scr2_cs_i, scr1_cs_i, obj_cs_i};
  assign addr[0] = obj_addr_i;
  assign addr[1] = scr1_addr_i;
  assign addr[2] = scr2_addr_i;
  assign addr[3] = scr3_addr_i;
  assign addr[4] = star_addr_i;

  // Round-robin search from last granted + 1; a requester whose ok is high this
  // cycle is still holding its old cs, so it is not yet a new request.
  always_comb begin
    int unsigned k;
    gnt_vld = 1'b0;
    gnt_idx = last_q;
    k       = 0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      k = (32'(last_q) + i) % NumReq;
      if (!gnt_vld && cs[k] && !ok_q[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k[2:0];
      end
    end
  end

  jtcps1_gfx_mappers u_mappers (
    .layer_i (gnt_idx),
    .cin_i   (gnt_raw[19:10]),
    .cout_o  (gnt_cout)
  );

  // Final ROM address of the candidate and the unmapped SCR3 decision
  always_comb begin
    gnt_raw      = addr[gnt_idx];
    gnt_unmapped = (gnt_idx == LayerScr3) && gnt_raw[16];
    gnt_addr     = (gnt_idx == LayerStar) ? gnt_raw : {gnt_cout, gnt_raw[9:0]};
  end

  // Arbitration FSM with registered memory and requester outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= LayerStar;
      sel_q      <= LayerObj;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      ok_q       <= '0;
      for (int i = 0; i < int'(NumReq); i++) data_q[i] <= '0;
    end else begin
      ok_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (gnt_vld) begin
            last_q <= gnt_idx;
            sel_q  <= gnt_idx;
            if (gnt_unmapped) begin
              state_q <= StBlank;
            end else begin
              rom_addr_q <= gnt_addr;
              rom_cs_q   <= 1'b1;
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          if (rom_ok_i) begin
            rom_cs_q <= 1'b0;
            state_q  <= StIdle;
            // Abandoned request: access finishes but the data is dropped
            if (cs[sel_q]) begin
              data_q[sel_q] <= rom_data_i;
              ok_q[sel_q]   <= 1'b1;
            end
          end
        end
        StBlank: begin
          data_q[sel_q] <= BlankWord;
          ok_q[sel_q]   <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_cs_o    = rom_cs_q;
  assign rom_addr_o  = rom_addr_q;
  assign obj_ok_o    = ok_q[0];
  assign scr1_ok_o   = ok_q[1];
  assign scr2_ok_o   = ok_q[2];
  assign scr3_ok_o   = ok_q[3];
  assign star_ok_o   = ok_q[4];
  assign obj_data_o  = data_q[0];
  assign scr1_data_o = data_q[1];
  assign scr2_data_o = data_q[2];
  assign scr3_data_o = data_q[3];
  assign star_data_o = data_q[4];

endmodule

// File: doc/jtcps1_gfx_rom_arb.md
JTCPS1_GFX_ROM_ARB -- requirements
Module: jtcps1_gfx_rom_arb

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 Requesters, index n = 0..4 = OBJ, SCR1, SCR2, SCR3, STAR:
- <n>_cs    input   1   request strobe.
- <n>_addr  input   20  layer-local word address.
- <n>_ok    output  1   one-cycle completion pulse.
- <n>_data  output  32  read data, valid while <n>_ok=1 and held until that requester's next completion.
REQ-004 rom_cs  output  1  memory request, held until rom_ok.
REQ-005 rom_addr  output  20  mapped GFX ROM word address.
REQ-006 rom_ok  input  1  memory completion pulse; rom_data is valid in the same cycle.
REQ-007 rom_data  input  32  memory read data.

Function
REQ-008 Layer code: OBJ=000, SCR1=001, SCR2=010, SCR3=011, STAR=100.
REQ-009 Mapping for layers 000-011: cin=addr[19:10]; a16=addr[16]; rom_addr={cout,addr[9:0]}.
- Bank A (layer 000, a16=1): cout = cin[2:0] + 40.
- Bank B (layer 011, a16=0): cout = cin[2:0] + 32.
- Bank C: cout = {0, cin[8:0]}. Applies to layer 000 with a16=0, and to layers 001 and 010 for any a16.
REQ-010 Layer 011 with a16=1 is unmapped; STAR bypasses mapping: rom_addr = addr.
REQ-011 FSM states: IDLE, ISSUE, BLANK.
REQ-012 IDLE: if any cs=1, grant one requester round-robin, searching from last-granted+1 with wrap 4->0, and latch its index and mapped address.
- Mapped request: go to ISSUE, with rom_cs=1 from the next cycle.
- Unmapped request: go to BLANK.
REQ-013 ISSUE: hold rom_cs and rom_addr stable until rom_ok=1.
- On rom_ok: register rom_data into the granted <n>_data, pulse <n>_ok in the next cycle, drop rom_cs in that same cycle, return to IDLE.
REQ-014 BLANK: with no memory access, pulse <n>_ok in the next cycle with <n>_data=32'hFFFFFFFF, then return to IDLE.
REQ-015 Latency and throughput:
- Best case, grant to ok is 3 cycles when rom_ok arrives 1 cycle after rom_cs.
- IDLE may grant again in the cycle <n>_ok is high, so the next rom_cs can assert 1 cycle after an ok.
REQ-016 Last-granted pointer updates at each grant; at most one <n>_ok is high per cycle.
REQ-017 Requester contract: cs and addr are held until ok. cs still high in the cycle after ok counts as a new request.
REQ-018 Abandoned request (cs dropped while in ISSUE): the memory access completes, data is discarded, and no ok is pulsed.
REQ-019 rom_ok received outside ISSUE is ignored.
REQ-020 Addresses are unsigned. The bank offset add is 10-bit with no carry into addr[9:0]. cin[9] is discarded in bank C.

Reset
REQ-021 On rst assertion, asynchronously:
- state=IDLE; rom_cs=0; rom_addr=0.
- all <n>_ok=0; all <n>_data=0.
- last-granted=STAR, so OBJ wins first.
REQ-022 Reset during ISSUE aborts the request: no ok is issued, and rom_cs falls immediately.

Structure
REQ-023 Layer codes, bank offsets (40, 32), requester count and the blank word belong in the shared jtcps1 package.
REQ-024 Address mapping sits in one combinational sub-module, jtcps1_gfx_mappers, with inputs layer[2:0] and cin[9:0] and output cout[9:0]. The unmapped decision stays in the arbiter.

Verification
REQ-025 Scenario 1: OBJ addr 20'h10000, rom_ok 2 cycles after rom_cs, rom_data 32'h12345678 -> rom_addr 20'h0A000; OBJ_ok pulses once with OBJ_data 32'h12345678.
REQ-026 Scenario 2: SCR3 addr 20'h00C00 -> rom_addr 20'h08C00; SCR1 addr 20'h12345 -> rom_addr 20'h12345.
REQ-027 Scenario 3: SCR3 addr 20'h10000 -> rom_cs never rises; SCR3_ok pulses in the 2nd cycle after the cs sample with data 32'hFFFFFFFF.
REQ-028 Scenario 4: all five cs held high continuously from reset -> grant order OBJ, SCR1, SCR2, SCR3, STAR, OBJ; no ok overlap.
REQ-029 Scenario 5: SCR2 drops cs mid-ISSUE -> no SCR2_ok; the pending OBJ request is granted after rom_ok.
REQ-030 Scenario 6: rst pulsed while rom_cs=1 -> rom_cs=0 and all outputs at reset values, asynchronously; the next grant goes to OBJ.
